// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU: opcode
// encodings, the control FSM state type and small opcode helpers.
package alu_pkg;

    // Opcode encodings (4-bit alu_op field).
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_NOT  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Encodings 1011..1111 are undefined and raise op_err.
    function automatic logic alu_op_defined(input logic [3:0] op);
        return (op <= ALU_SLTU);
    endfunction

    // Only the multiply goes through the iterative engine.
    function automatic logic alu_op_is_mul(input logic [3:0] op);
        return (op == ALU_MUL);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_mc_booth_seq.sv
// Iterative radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH.
// i_load captures the operands; every i_step cycle performs one Booth
// iteration. o_done flags the cycle whose step is the last one, and
// o_product then carries the product that step produces, so the caller
// can register it on the same edge without an extra cycle.
module booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // A and M carry one extra bit so that M = -2^(WIDTH-1) can be
    // subtracted without overflowing the partial-product accumulator.
    logic [WIDTH:0]     r_a;
    logic [WIDTH:0]     r_m;
    logic [WIDTH-1:0]   r_q;
    logic               r_q1;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic [WIDTH:0]     w_a_sum;

    // Booth add/subtract selected by the pair {Q[0], q_1}.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        w_a_sum = r_a;
        unique case ({r_q[0], r_q1})
            2'b01:   w_a_sum = r_a + r_m;
            2'b10:   w_a_sum = r_a - r_m;
            default: w_a_sum = r_a;
        endcase
    end

    // Last iteration is a decode of registered state only.
    assign o_done    = r_busy && (r_count == LAST_ITER);

    // After the arithmetic shift, {A[WIDTH-1:0], Q} equals {A_sum, Q[WIDTH-1:1]}.
    assign o_product = {w_a_sum, r_q[WIDTH-1:1]};

    // Iteration counter and busy flag; these are the only control state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update from the pre-edge values, with no ordering races.
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (i_load) begin
            r_busy  <= 1'b1;
            r_count <= '0;
        end else if (i_step && r_busy) begin
            if (o_done) begin
                r_busy  <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Booth datapath: load operands, then add/sub and arithmetic right shift.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are deliberately not reset; they are
        // always written by i_load before being read, so a reset would only
        // add routing to wide registers.
        if (i_load) begin
            r_a  <= '0;
            r_m  <= {i_multiplicand[WIDTH-1], i_multiplicand};
            r_q  <= i_multiplier;
            r_q1 <= 1'b0;
        end else if (i_step && r_busy) begin
            r_a  <= {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
            r_q  <= {w_a_sum[0], r_q[WIDTH-1:1]};
            r_q1 <= r_q[0];
        end
    end

endmodule : booth_seq

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU. One operation per valid/ready handshake;
// single-cycle ops complete in one cycle, signed multiply runs through the
// Booth engine for WIDTH cycles. The result is held in DONE until the
// consumer takes it, so EX/MEM can stall on in_ready / out_valid.
// WIDTH must be at least 4 and even.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_op,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    input  logic [SHW-1:0]     shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               zero,
    output logic               op_err
);

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_live;
    logic                 w_accept;
    logic                 w_accept_mul;
    logic                 w_accept_single;
    logic [WIDTH-1:0]     w_alu;
    logic                 w_op_err;
    logic                 w_booth_done;
    logic [2*WIDTH-1:0]   w_booth_product;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_zero;
    logic                 r_op_err;

    assign w_accept        = in_valid && in_ready;
    assign w_accept_mul    = w_accept && alu_op_is_mul(alu_op);
    assign w_accept_single = w_accept && !alu_op_is_mul(alu_op);

    // State register; r_live holds in_ready low until the first edge after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
        end
    end

    // Next-state logic: IDLE -> MUL/DONE on accept, MUL -> DONE on last step.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = alu_op_is_mul(alu_op) ? MUL : DONE;
                end
            end
            MUL: begin
                if (w_booth_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        in_ready  = r_live && (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Single-cycle datapath; results are WIDTH bits, zero-extended on register.
    always_comb begin
        w_alu    = '0;
        w_op_err = !alu_op_defined(alu_op);
        unique case (alu_op)
            ALU_ADD:  w_alu = input1 + input2;
            ALU_SUB:  w_alu = input1 - input2;
            ALU_NOT:  w_alu = ~input1;
            ALU_SLL:  w_alu = input1 << shamt;
            ALU_SRL:  w_alu = input1 >> shamt;
            ALU_AND:  w_alu = input1 & input2;
            ALU_OR:   w_alu = input1 | input2;
            ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            ALU_SRA:  w_alu = $unsigned($signed(input1) >>> shamt);
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            default:  w_alu = '0;
        endcase
    end

    // Booth engine: loaded on a MUL accept, stepped every cycle in MUL.
    booth_seq #(
        .WIDTH (WIDTH)
    ) u_booth (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_load         (w_accept_mul),
        .i_step         (r_state == MUL),
        .i_multiplicand (input1),
        .i_multiplier   (input2),
        .o_done         (w_booth_done),
        .o_product      (w_booth_product)
    );

    // Output registers: written at single-cycle accept or final Booth step,
    // otherwise held, which keeps them stable while DONE waits for out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_op_err <= 1'b0;
        end else if (w_accept_single) begin
            r_result <= {{WIDTH{1'b0}}, w_alu};
            r_zero   <= (w_alu == '0);
            r_op_err <= w_op_err;
        end else if ((r_state == MUL) && w_booth_done) begin
            r_result <= w_booth_product;
            r_zero   <= (w_booth_product == '0);
            r_op_err <= 1'b0;
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign op_err = r_op_err;

endmodule : alu_mc
